// File: rtl/lbirow_pkg.sv
// Shared state encoding and parameter-derivation helpers for the row engine.
package lbirow_pkg;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RUNNING = 2'd1,
        S_DONE    = 2'd2
    } lbirow_state_e;

    function automatic int lbirow_clog2(input int value);
        int res;
        int pow;
        res = 32'sd0;
        pow = 32'sd1;
        while (pow < value) begin
            pow = pow * 32'sd2;
            res = res + 32'sd1;
        end
        return res;
    endfunction

    function automatic int lbirow_chunk_w(input int randomsize);
        return randomsize / 32'sd6;
    endfunction

    function automatic int lbirow_num_part(input int inputsize, input int chunk_w);
        return (inputsize + chunk_w - 32'sd1) / chunk_w;
    endfunction

    function automatic int lbirow_ngrp(input int num_part, input int lanes);
        return (num_part + lanes - 32'sd1) / lanes;
    endfunction

    function automatic int lbirow_wgt_w(input int inputsize);
        return lbirow_clog2(inputsize + 32'sd1);
    endfunction

endpackage

// File: rtl/lbirow_lane.sv
// One chunk of the row: XOR with its random slot, clear pad bits, popcount.
module lbirow_lane
    import lbirow_pkg::*;
#(
    parameter int CHUNK_W = 16,
    parameter int PC_W    = 5
) (
    input  logic               active_i,
    input  logic [CHUNK_W-1:0] chunk_i,
    input  logic [CHUNK_W-1:0] mask_i,
    input  logic [CHUNK_W-1:0] valid_i,
    output logic [CHUNK_W-1:0] chunk_o,
    output logic [PC_W-1:0]    pop_o
);

    // Inactive lanes pass the chunk through untouched and count nothing.
    always_comb begin
        chunk_o = chunk_i;
        pop_o   = '0;
        if (active_i) begin
            chunk_o = (chunk_i ^ mask_i) & valid_i;
            for (int b = 0; b < CHUNK_W; b++) begin
                pop_o = pop_o + PC_W'(chunk_o[b]);
            end
        end else begin
            chunk_o = chunk_i;
        end
    end

endmodule

// File: rtl/lbirow_engine.sv
// Row partitioner: masks a padded message row chunk-wise and accumulates its weight.
// Optional macro LBIROW_RESTART_EN lets a new message abort a busy row.
module lbirow_engine
    import lbirow_pkg::*;
#(
    parameter int INPUTSIZE  = 840,
    parameter int RANDOMSIZE = 96,
    parameter int LANES      = 1
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [INPUTSIZE-1:0]                msg_in,
    input  logic                                msgin_vld,
    output logic                                msgin_rdy,
    input  logic [RANDOMSIZE-1:0]               randomin,
    output logic [INPUTSIZE-1:0]                msg_out,
    output logic [lbirow_wgt_w(INPUTSIZE)-1:0]  row_weight,
    output logic                                msgout_vld,
    input  logic                                msgout_rdy
);

    localparam int CHUNK_W  = lbirow_chunk_w(RANDOMSIZE);
    localparam int NUM_PART = lbirow_num_part(INPUTSIZE, CHUNK_W);
    localparam int NGRP     = lbirow_ngrp(NUM_PART, LANES);
    localparam int WGT_W    = lbirow_wgt_w(INPUTSIZE);
    localparam int ROW_W    = NUM_PART * CHUNK_W;
    localparam int PC_W     = lbirow_clog2(CHUNK_W + 1);
    localparam int CNT_W    = (NGRP > 1) ? lbirow_clog2(NGRP) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NGRP - 1);

    lbirow_state_e          state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [WGT_W-1:0]       acc_q, acc_d;
    logic [ROW_W-1:0]       row_q, row_d;
    logic [RANDOMSIZE-1:0]  rand_q, rand_d;
    logic [INPUTSIZE-1:0]   out_q, out_d;
    logic [WGT_W-1:0]       wgt_q, wgt_d;
    logic                   vld_q, vld_d;
    logic                   rdy_q, rdy_d;
    logic                   accept_s;

    logic [ROW_W-1:0]       row_step_s;
    logic [WGT_W-1:0]       lane_sum_s;
    logic [CHUNK_W-1:0]     lane_out_s [LANES];
    logic [PC_W-1:0]        lane_pop_s [LANES];
    int                     lane_k_s   [LANES];
    logic                   lane_act_s [LANES];

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        logic [CHUNK_W-1:0] in_s;
        logic [CHUNK_W-1:0] mask_s;
        logic [CHUNK_W-1:0] valid_s;
        logic               act_s;
        int                 kraw_s;
        int                 k_s;

        // Out-of-range lanes are parked on chunk 0 so every select stays in bounds.
        always_comb begin
            kraw_s = int'(cnt_q) * LANES + g;
            act_s  = (kraw_s < NUM_PART);
            k_s    = act_s ? kraw_s : 32'sd0;
            in_s   = row_q[k_s * CHUNK_W +: CHUNK_W];
            mask_s = rand_q[(k_s % 32'sd6) * CHUNK_W +: CHUNK_W];
            for (int b = 0; b < CHUNK_W; b++) begin
                valid_s[b] = ((k_s * CHUNK_W + b) < INPUTSIZE);
            end
        end

        lbirow_lane #(
            .CHUNK_W (CHUNK_W),
            .PC_W    (PC_W)
        ) u_lane (
            .active_i (act_s),
            .chunk_i  (in_s),
            .mask_i   (mask_s),
            .valid_i  (valid_s),
            .chunk_o  (lane_out_s[g]),
            .pop_o    (lane_pop_s[g])
        );

        assign lane_k_s[g]   = k_s;
        assign lane_act_s[g] = act_s;
    end

    // Merge lane results into the row image and sum their popcounts.
    always_comb begin
        row_step_s = row_q;
        lane_sum_s = '0;
        for (int j = 0; j < LANES; j++) begin
            row_step_s[lane_k_s[j] * CHUNK_W +: CHUNK_W] =
                lane_act_s[j] ? lane_out_s[j] : row_step_s[lane_k_s[j] * CHUNK_W +: CHUNK_W];
            lane_sum_s = lane_sum_s + WGT_W'(lane_pop_s[j]);
        end
    end

    // Next-state and registered-output logic; a new accept overrides the current state.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        row_d   = row_q;
        rand_d  = rand_q;
        out_d   = out_q;
        wgt_d   = wgt_q;
        vld_d   = vld_q;
`ifdef LBIROW_RESTART_EN
        accept_s = msgin_vld;
`else
        accept_s = msgin_vld && (state_q == S_IDLE);
`endif
        if (accept_s) begin
            row_d   = ROW_W'(msg_in);
            rand_d  = randomin;
            cnt_d   = '0;
            acc_d   = '0;
            vld_d   = 1'b0;
            state_d = S_RUNNING;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d = S_IDLE;
                end
                S_RUNNING: begin
                    row_d = row_step_s;
                    acc_d = acc_q + lane_sum_s;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_LAST) begin
                        state_d = S_DONE;
                        vld_d   = 1'b1;
                        out_d   = row_step_s[INPUTSIZE-1:0];
                        wgt_d   = acc_q + lane_sum_s;
                    end else begin
                        state_d = S_RUNNING;
                    end
                end
                S_DONE: begin
                    if (msgout_rdy) begin
                        state_d = S_IDLE;
                        vld_d   = 1'b0;
                    end else begin
                        state_d = S_DONE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    vld_d   = 1'b0;
                end
            endcase
        end
`ifdef LBIROW_RESTART_EN
        rdy_d = 1'b1;
`else
        rdy_d = (state_d == S_IDLE);
`endif
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            row_q   <= '0;
            rand_q  <= '0;
            out_q   <= '0;
            wgt_q   <= '0;
            vld_q   <= 1'b0;
            rdy_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            row_q   <= row_d;
            rand_q  <= rand_d;
            out_q   <= out_d;
            wgt_q   <= wgt_d;
            vld_q   <= vld_d;
            rdy_q   <= rdy_d;
        end
    end

    assign msgin_rdy  = rdy_q;
    assign msgout_vld = vld_q;
    assign msg_out    = out_q;
    assign row_weight = wgt_q;

endmodule

// File: tb/tb_lbirow_engine.sv
// Self-checking bench: one LANES=1 and one LANES=4 engine against a bit-level reference model.
module tb_lbirow_engine;

    localparam int IN    = 840;
    localparam int RS    = 96;
    localparam int CW    = RS / 6;
    localparam int LAT1  = 54;
    localparam int LAT4  = 15;

    logic          clk = 1'b0;
    logic          reset;
    logic [IN-1:0] msg_in;
    logic [RS-1:0] randomin;
    logic          vin1, vin4, ordy1, ordy4;
    logic          irdy1, irdy4, vout1, vout4;
    logic [IN-1:0] mout1, mout4;
    logic [9:0]    wout1, wout4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lbirow_engine #(.INPUTSIZE(IN), .RANDOMSIZE(RS), .LANES(1)) dut1 (
        .clk(clk), .reset(reset), .msg_in(msg_in), .msgin_vld(vin1), .msgin_rdy(irdy1),
        .randomin(randomin), .msg_out(mout1), .row_weight(wout1), .msgout_vld(vout1),
        .msgout_rdy(ordy1)
    );

    lbirow_engine #(.INPUTSIZE(IN), .RANDOMSIZE(RS), .LANES(4)) dut4 (
        .clk(clk), .reset(reset), .msg_in(msg_in), .msgin_vld(vin4), .msgin_rdy(irdy4),
        .randomin(randomin), .msg_out(mout4), .row_weight(wout4), .msgout_vld(vout4),
        .msgout_rdy(ordy4)
    );

    typedef struct {
        logic [IN-1:0] msg;
        logic [RS-1:0] rnd;
        logic [IN-1:0] exp_msg;
        int            exp_wgt;
    } vec_t;

    task automatic check(input string name, input logic [1023:0] got, input logic [1023:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Bit i lives in chunk i/CW, which uses random slot (chunk mod 6).
    task automatic model(input logic [IN-1:0] m, input logic [RS-1:0] r,
                         output logic [IN-1:0] o, output int w);
        for (int i = 0; i < IN; i++) begin
            o[i] = m[i] ^ r[((i / CW) % 6) * CW + (i % CW)];
        end
        w = $countones(o);
    endtask

    task automatic rand_row(output logic [IN-1:0] m, output logic [RS-1:0] r);
        for (int i = 0; i < IN; i++) m[i] = 1'($urandom_range(1, 0));
        for (int i = 0; i < RS; i++) r[i] = 1'($urandom_range(1, 0));
    endtask

    task automatic run_row(input bit use4, input logic [IN-1:0] m, input logic [RS-1:0] r,
                           output logic [IN-1:0] om, output int ow, output int lat);
        msg_in   = m;
        randomin = r;
        if (use4) vin4 = 1'b1; else vin1 = 1'b1;
        lat = 0;
        do begin
            @(posedge clk); #1;
            vin1 = 1'b0;
            vin4 = 1'b0;
            lat++;
        end while (!(use4 ? vout4 : vout1) && lat < 200);
        om = use4 ? mout4 : mout1;
        ow = int'(use4 ? wout4 : wout1);
    endtask

    task automatic consume(input bit use4);
        if (use4) ordy4 = 1'b1; else ordy1 = 1'b1;
        @(posedge clk); #1;
        ordy1 = 1'b0;
        ordy4 = 1'b0;
    endtask

    task automatic check_row(input string tag, input bit use4, input logic [IN-1:0] m,
                             input logic [RS-1:0] r);
        logic [IN-1:0] om, em;
        int ow, ew, lat;
        model(m, r, em, ew);
        run_row(use4, m, r, om, ow, lat);
        check({tag, "_lat"}, 1024'(lat), 1024'(use4 ? LAT4 : LAT1));
        check({tag, "_msg"}, 1024'(om), 1024'(em));
        check({tag, "_wgt"}, 1024'(ow), 1024'(ew));
        consume(use4);
    endtask

    initial begin
        vec_t          vecs[4];
        logic [IN-1:0] ones, a55, aaa, m, om, em, hold_m;
        logic [RS-1:0] r, rones;
        int            ow, ew, lat, hold_w;

        ones  = '1;
        rones = '1;
        a55   = {105{8'h55}};
        aaa   = {105{8'haa}};
        vecs[0] = '{msg: ones,      rnd: '0,    exp_msg: ones,      exp_wgt: 840};
        vecs[1] = '{msg: a55,       rnd: rones, exp_msg: aaa,       exp_wgt: 420};
        vecs[2] = '{msg: ones,      rnd: rones, exp_msg: {IN{1'b0}}, exp_wgt: 0};
        vecs[3] = '{msg: {IN{1'b0}}, rnd: rones, exp_msg: ones,      exp_wgt: 840};

        reset = 1'b1; vin1 = 1'b0; vin4 = 1'b0; ordy1 = 1'b0; ordy4 = 1'b0;
        msg_in = '0; randomin = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        check("rst_rdy1", 1024'(irdy1), 1024'(1));
        check("rst_vld1", 1024'(vout1), 1024'(0));
        check("rst_msg1", 1024'(mout1), 1024'(0));
        check("rst_wgt1", 1024'(wout1), 1024'(0));
        check("rst_rdy4", 1024'(irdy4), 1024'(1));
        check("rst_vld4", 1024'(vout4), 1024'(0));

        // Directed table on both lane counts.
        for (int u = 0; u < 2; u++) begin
            for (int v = 0; v < 4; v++) begin
                run_row(u == 1, vecs[v].msg, vecs[v].rnd, om, ow, lat);
                check($sformatf("tbl%0d_l%0d_lat", v, u), 1024'(lat), 1024'(u == 1 ? LAT4 : LAT1));
                check($sformatf("tbl%0d_l%0d_msg", v, u), 1024'(om), 1024'(vecs[v].exp_msg));
                check($sformatf("tbl%0d_l%0d_wgt", v, u), 1024'(ow), 1024'(vecs[v].exp_wgt));
                consume(u == 1);
            end
        end

        // Random rows against the reference model.
        for (int n = 0; n < 8; n++) begin
            rand_row(m, r);
            check_row($sformatf("rnd4_%0d", n), 1'b1, m, r);
        end
        for (int n = 0; n < 3; n++) begin
            rand_row(m, r);
            check_row($sformatf("rnd1_%0d", n), 1'b0, m, r);
        end

`ifndef LBIROW_RESTART_EN
        // Back-pressure in DONE with a stray message that must be ignored.
        rand_row(m, r);
        model(m, r, em, ew);
        run_row(1'b0, m, r, hold_m, hold_w, lat);
        check("bp_first_msg", 1024'(hold_m), 1024'(em));
        for (int c = 0; c < 10; c++) begin
            if (c == 3) begin
                rand_row(m, r);
                vin1 = 1'b1;
            end
            @(posedge clk); #1;
            vin1 = 1'b0;
            check($sformatf("bp_vld_%0d", c), 1024'(vout1), 1024'(1));
            check($sformatf("bp_irdy_%0d", c), 1024'(irdy1), 1024'(0));
            check($sformatf("bp_msg_%0d", c), 1024'(mout1), 1024'(hold_m));
            check($sformatf("bp_wgt_%0d", c), 1024'(wout1), 1024'(hold_w));
        end
        consume(1'b0);
        check("bp_vld_after", 1024'(vout1), 1024'(0));
        check("bp_irdy_after", 1024'(irdy1), 1024'(1));
        check("bp_msg_kept", 1024'(mout1), 1024'(hold_m));
        rand_row(m, r);
        check_row("bp_next", 1'b0, m, r);
`endif

        // Reset in the middle of a row.
        rand_row(m, r);
        msg_in = m; randomin = r; vin1 = 1'b1;
        @(posedge clk); #1;
        vin1 = 1'b0;
        repeat (20) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("mrst_vld", 1024'(vout1), 1024'(0));
        check("mrst_msg", 1024'(mout1), 1024'(0));
        check("mrst_wgt", 1024'(wout1), 1024'(0));
        check("mrst_rdy", 1024'(irdy1), 1024'(1));
        rand_row(m, r);
        check_row("mrst_next", 1'b0, m, r);

`ifdef LBIROW_RESTART_EN
        // Restart mid-row: the first row is never presented.
        rand_row(m, r);
        msg_in = m; randomin = r; vin1 = 1'b1;
        @(posedge clk); #1;
        vin1 = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        check("rs_irdy_busy", 1024'(irdy1), 1024'(1));
        rand_row(m, r);
        check_row("rs_second", 1'b0, m, r);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
